// File: rtl/hdc_am_pkg.sv
// Shared constants and types for the hyperdimensional associative-memory search.
// A class hypervector is NUM_FRAMES frames of FRAME_W bits (D = 192).
package hdc_am_pkg;

    localparam int NUM_CLASSES = 8;
    localparam int NUM_FRAMES  = 3;
    localparam int FRAME_W     = 64;
    localparam int CLASS_W     = 3;   // clog2(NUM_CLASSES)
    localparam int FIDX_W      = 2;   // clog2(NUM_FRAMES)
    localparam int DIST_W      = 8;   // clog2(NUM_FRAMES*FRAME_W + 1)

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [FIDX_W-1:0]  LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

    // Larger than any reachable distance (max 192), so class 0 always
    // replaces the initial best.
    localparam logic [DIST_W-1:0]  DIST_INIT  = '1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of one frame, built as a binary adder tree.
// Ports:
//   data_i  - IN_W-bit input word
//   count_o - number of set bits in data_i
// IN_W must be a power of two.
module popcount64 #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] count_o
);

    logic [OUT_W-1:0] leaf [IN_W];
    // Heap-ordered tree: node[i] = node[2i] + node[2i+1]; leaves at IN_W..2*IN_W-1.
    logic [OUT_W-1:0] node [1:2*IN_W-1];

    genvar gi;
    generate
        for (gi = 0; gi < IN_W; gi++) begin : g_leaf
            assign leaf[gi] = OUT_W'(data_i[gi]);
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            node[IN_W + i] = leaf[i];
        end
        for (int i = IN_W - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i + 1];
        end
        count_o = node[1];
    end

endmodule

// File: rtl/hdc_am_search.sv
// Associative-memory search: buffers a frame-serial query hypervector, walks
// the class ROM one frame per cycle, accumulates the Hamming distance per
// class and reports the class with the minimum distance (ties -> lower index).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   q_valid/q_ready/q_data   - query frame stream, frames 0..NUM_FRAMES-1 in order
//   rom_frame_id/_index      - registered ROM address (class, frame)
//   rom_data                 - combinational ROM output for the current address
//   res_valid/res_ready      - result handshake
//   res_class/res_dist       - best class and its Hamming distance
module hdc_am_search
    import hdc_am_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    output logic               q_ready,
    input  logic [FRAME_W-1:0] q_data,
    output logic [CLASS_W-1:0] rom_frame_id,
    output logic [FIDX_W-1:0]  rom_frame_index,
    input  logic [FRAME_W-1:0] rom_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic [DIST_W-1:0]  res_dist
);

    state_e              state_q, state_d;
    logic [FIDX_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CLASS_W-1:0]  cls_q, cls_d;
    logic [FIDX_W-1:0]   fr_q, fr_d;
    logic [DIST_W-1:0]   acc_q, acc_d;
    logic [DIST_W-1:0]   best_dist_q, best_dist_d;
    logic [CLASS_W-1:0]  best_cls_q, best_cls_d;
    logic                res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]  res_class_q, res_class_d;
    logic [DIST_W-1:0]   res_dist_q, res_dist_d;

    logic [FRAME_W-1:0]  qbuf_q [NUM_FRAMES];
    logic [DIST_W-1:0]   pc;
    logic [DIST_W-1:0]   dist_sum;
    logic                q_accept;

    assign q_ready         = (state_q == ST_LOAD);
    assign q_accept        = q_valid && q_ready;
    assign rom_frame_id    = cls_q;
    assign rom_frame_index = fr_q;
    assign res_valid       = res_valid_q;
    assign res_class       = res_class_q;
    assign res_dist        = res_dist_q;

    popcount64 #(
        .IN_W  (FRAME_W),
        .OUT_W (DIST_W)
    ) u_popcount (
        .data_i  (qbuf_q[fr_q] ^ rom_data),
        .count_o (pc)
    );

    // Query buffer: plain write-enabled array, no reset needed since a full
    // query is always loaded before it is read.
    always_ff @(posedge clk) begin
        if (q_accept) begin
            qbuf_q[load_cnt_q] <= q_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            cls_q       <= '0;
            fr_q        <= '0;
            acc_q       <= '0;
            best_dist_q <= '0;
            best_cls_q  <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_dist_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            cls_q       <= cls_d;
            fr_q        <= fr_d;
            acc_q       <= acc_d;
            best_dist_q <= best_dist_d;
            best_cls_q  <= best_cls_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_dist_q  <= res_dist_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        cls_d       = cls_q;
        fr_d        = fr_q;
        acc_d       = acc_q;
        best_dist_d = best_dist_q;
        best_cls_d  = best_cls_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_dist_d  = res_dist_q;
        dist_sum    = acc_q + pc;

        unique case (state_q)
            ST_LOAD: begin
                if (q_accept) begin
                    if (load_cnt_q == LAST_FRAME) begin
                        state_d     = ST_SEARCH;
                        load_cnt_d  = '0;
                        cls_d       = '0;
                        fr_d        = '0;
                        acc_d       = '0;
                        best_dist_d = DIST_INIT;
                        best_cls_d  = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end

            ST_SEARCH: begin
                if (fr_q != LAST_FRAME) begin
                    acc_d = dist_sum;
                    fr_d  = fr_q + 1'b1;
                end else begin
                    // Strict compare: an equal distance keeps the earlier class.
                    if (dist_sum < best_dist_q) begin
                        best_dist_d = dist_sum;
                        best_cls_d  = cls_q;
                    end
                    acc_d = '0;
                    fr_d  = '0;
                    cls_d = cls_q + 1'b1;
                    if (cls_q == LAST_CLASS) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // First DONE cycle latches the result; it then holds until taken.
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    load_cnt_d  = '0;
                    state_d     = ST_LOAD;
                end else begin
                    res_valid_d = 1'b1;
                    res_class_d = best_cls_q;
                    res_dist_d  = best_dist_q;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_hdc_am_search.sv
module tb_hdc_am_search;
    import hdc_am_pkg::*;

    typedef logic [FRAME_W-1:0] hv_t [NUM_FRAMES];

    typedef struct {
        string name;
        int    base;
        int    nflip;
        bit    invert;
        bit    stub;
        int    exp_cls;
        int    exp_dist;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               q_valid;
    logic               q_ready;
    logic [FRAME_W-1:0] q_data;
    logic [CLASS_W-1:0] rom_frame_id;
    logic [FIDX_W-1:0]  rom_frame_index;
    logic [FRAME_W-1:0] rom_data;
    logic               res_valid;
    logic               res_ready;
    logic [CLASS_W-1:0] res_class;
    logic [DIST_W-1:0]  res_dist;

    bit stub_mode = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hdc_am_search dut (
        .clk             (clk),
        .rst             (rst),
        .q_valid         (q_valid),
        .q_ready         (q_ready),
        .q_data          (q_data),
        .rom_frame_id    (rom_frame_id),
        .rom_frame_index (rom_frame_index),
        .rom_data        (rom_data),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_class       (res_class),
        .res_dist        (res_dist)
    );

    // Pseudo-random class vectors standing in for class_vec_gen.
    function automatic logic [63:0] golden_rom(input int c, input int f);
        logic [63:0] x;
        x = 64'(c * 3 + f + 1) * 64'h9E3779B97F4A7C15;
        x = x ^ (x >> 29);
        x = x * 64'hBF58476D1CE4E5B9;
        x = x ^ (x >> 32);
        return x;
    endfunction

    // Stub ROM: same data for every class, each frame has 10 set bits.
    function automatic logic [63:0] rom_word(input int c, input int f, input bit stub);
        logic [63:0] base;
        base = 64'h3FF;
        if (stub) return base << (8 * f);
        return golden_rom(c, f);
    endfunction

    assign rom_data = rom_word(int'(rom_frame_id), int'(rom_frame_index), stub_mode);

    function automatic void model_search(input hv_t q, input bit stub,
                                         output int bcls, output int bdist);
        int d;
        bdist = 1000;
        bcls  = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            d = 0;
            for (int f = 0; f < NUM_FRAMES; f++) begin
                d += $countones(q[f] ^ rom_word(c, f, stub));
            end
            if (d < bdist) begin
                bdist = d;
                bcls  = c;
            end
        end
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic build_query(input int base, input int nflip, input bit invert,
                               input bit stub, output hv_t q);
        logic [63:0] mask;
        mask = (nflip >= 64) ? '1 : ((64'd1 << nflip) - 64'd1);
        for (int f = 0; f < NUM_FRAMES; f++) begin
            q[f] = stub ? 64'd0 : golden_rom(base, f);
            if (invert) q[f] = ~q[f];
        end
        q[0] = q[0] ^ mask;
    endtask

    // Ends #1 after the edge that accepted the last frame.
    task automatic send_query(input hv_t q, input bit gapped);
        bit pat [6];
        int fi;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        check("q_ready_before_load", q_ready, 1);
        if (!gapped) begin
            for (int f = 0; f < NUM_FRAMES; f++) begin
                q_valid = 1'b1;
                q_data  = q[f];
                @(posedge clk); #1;
            end
        end else begin
            fi = 0;
            for (int s = 0; s < 6; s++) begin
                q_valid = pat[s];
                q_data  = pat[s] ? q[fi] : ~q[fi];
                @(posedge clk); #1;
                if (pat[s]) fi++;
            end
        end
        q_valid = 1'b0;
        q_data  = '0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!res_valid) begin
            tests++;
            fails++;
            $display("FAIL res_valid_timeout: got 0 after %0d cycles, expected 1", cycles);
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_after_handshake", res_valid, 0);
    endtask

    task automatic run_expect(input string name, input hv_t q, input bit gapped,
                              input int ecls, input int edist);
        int cyc;
        send_query(q, gapped);
        wait_result(cyc);
        check({name, "_class"}, res_class, ecls);
        check({name, "_dist"}, res_dist, edist);
        handshake();
        $display("[TB] %s: class=%0d dist=%0d latency=%0d", name, res_class, res_dist, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        hv_t  q;
        int   cyc, mcls, mdist;

        rst = 1'b1; q_valid = 1'b0; q_data = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q_ready", q_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_dist", res_dist, 0);
        check("rst_rom_id", rom_frame_id, 0);
        check("rst_rom_idx", rom_frame_index, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Exact match with latency measurement.
        build_query(3, 0, 1'b0, 1'b0, q);
        send_query(q, 1'b0);
        check("search_start_rom_id", rom_frame_id, 0);
        check("search_start_rom_idx", rom_frame_index, 0);
        wait_result(cyc);
        check("exact3_latency", cyc, 25);
        check("exact3_class", res_class, 3);
        check("exact3_dist", res_dist, 0);
        check("exact3_q_ready", q_ready, 0);
        handshake();
        $display("[TB] exact3: class=%0d dist=%0d latency=%0d", res_class, res_dist, cyc);

        // Table of directed vectors.
        vecs[0] = '{"exact0",  0, 0,  1'b0, 1'b0, 0, 0};
        vecs[1] = '{"exact7",  7, 0,  1'b0, 1'b0, 7, 0};
        vecs[2] = '{"flip2x5", 2, 5,  1'b0, 1'b0, 2, 5};
        vecs[3] = '{"flip6x17",6, 17, 1'b0, 1'b0, 6, 17};
        vecs[4] = '{"tie_stub",0, 0,  1'b0, 1'b1, 0, 30};
        vecs[5] = '{"invert5", 5, 0,  1'b1, 1'b0, -1, -1};
        build_query(5, 0, 1'b1, 1'b0, q);
        model_search(q, 1'b0, mcls, mdist);
        vecs[5].exp_cls  = mcls;
        vecs[5].exp_dist = mdist;

        for (int i = 0; i < 6; i++) begin
            stub_mode = vecs[i].stub;
            build_query(vecs[i].base, vecs[i].nflip, vecs[i].invert, vecs[i].stub, q);
            run_expect(vecs[i].name, q, 1'b0, vecs[i].exp_cls, vecs[i].exp_dist);
        end
        stub_mode = 1'b0;
        tests++;
        if (vecs[5].exp_cls == 5) begin
            fails++;
            $display("FAIL invert5_not5: got class 5, expected any other class");
        end

        // Back-pressure with ignored query pulses.
        build_query(1, 0, 1'b0, 1'b0, q);
        send_query(q, 1'b0);
        wait_result(cyc);
        for (int i = 0; i < 10; i++) begin
            q_valid = (i % 2 == 0);
            q_data  = {$urandom, $urandom};
            check("bp_res_valid", res_valid, 1);
            check("bp_res_class", res_class, 1);
            check("bp_res_dist", res_dist, 0);
            check("bp_q_ready", q_ready, 0);
            @(posedge clk); #1;
        end
        q_valid = 1'b0;
        handshake();
        $display("[TB] backpressure: held 10 cycles, class=%0d dist=%0d", res_class, res_dist);
        build_query(4, 0, 1'b0, 1'b0, q);
        run_expect("after_bp4", q, 1'b0, 4, 0);

        // Gapped vs contiguous delivery of the same query.
        build_query(6, 3, 1'b0, 1'b0, q);
        run_expect("contig6x3", q, 1'b0, 6, 3);
        run_expect("gapped6x3", q, 1'b1, 6, 3);

        // Reset in the middle of a search.
        build_query(2, 0, 1'b0, 1'b0, q);
        send_query(q, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("mid_search_rom_id", rom_frame_id, 3);
        check("mid_search_rom_idx", rom_frame_index, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_q_ready", q_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_rom_id", rom_frame_id, 0);
        check("midrst_rom_idx", rom_frame_index, 0);
        $display("[TB] reset mid-search: q_ready=%0d res_valid=%0d", q_ready, res_valid);
        build_query(3, 0, 1'b0, 1'b0, q);
        run_expect("after_rst3", q, 1'b0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
